// File: rtl/fft_buf_pkg.sv
// Shared types and helpers for the FFT ping-pong sample buffer.
// Holds the ownership FSM encoding and the bit-reverse address helper.
package fft_buf_pkg;

    typedef enum logic [1:0] {
        FILL,
        FILL_READ,
        STALL
    } buf_state_t;

    localparam int BR_MAX_W = 32;

    // Reverses the low w bits of a; bits above w come back as zero.
    function automatic logic [BR_MAX_W-1:0] bitrev(
        input logic [BR_MAX_W-1:0] a,
        input int                  w
    );
        logic [BR_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < BR_MAX_W; i++) begin
            if (i < w) r[i] = a[w-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_pingpong_buf_if.sv
// Sample stream and FFT bank port bundle for the ping-pong buffer.
// The master side is the sample source plus the FFT core.
interface fft_pingpong_buf_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
);
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              frame_ready;
    logic              overrun;
    logic [ADDR_W-1:0] fft_rd_addr;
    logic              fft_rd_bitrev;
    logic [DATA_W-1:0] fft_rd_data;
    logic              fft_we;
    logic [ADDR_W-1:0] fft_wr_addr;
    logic [DATA_W-1:0] fft_wr_data;
    logic              fft_release;

    modport master (
        output s_valid, s_data,
        output fft_rd_addr, fft_rd_bitrev,
        output fft_we, fft_wr_addr, fft_wr_data,
        output fft_release,
        input  s_ready, frame_ready, overrun,
        input  fft_rd_data
    );

    modport slave (
        input  s_valid, s_data,
        input  fft_rd_addr, fft_rd_bitrev,
        input  fft_we, fft_wr_addr, fft_wr_data,
        input  fft_release,
        output s_ready, frame_ready, overrun,
        output fft_rd_data
    );
endinterface

// File: rtl/ram_bank.sv
// Simple dual-port synchronous RAM: one write port, one registered read.
// Read and write to the same address in one cycle returns the old word.
module ram_bank #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) rdata <= '0;
        else       rdata <= mem[raddr];
    end
endmodule

// File: rtl/fft_pingpong_buf.sv
// Two-bank sample buffer: stream fills bank wr_bank, FFT owns ~wr_bank.
// Banks swap when a frame completes and the FFT has released its bank.
module fft_pingpong_buf
    import fft_buf_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
) (
    input logic                 clk,
    input logic                 reset,
    fft_pingpong_buf_if.slave   bus
);
    buf_state_t        state;
    logic              wr_bank;
    logic [ADDR_W-1:0] wr_cnt;
    logic              s_ready_q;
    logic              frame_ready_q;
    logic              overrun_q;
    logic              rd_sel;
    logic              accept;
    logic              last;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rdata [2];

    assign accept = bus.s_valid && s_ready_q;
    assign last   = accept && (wr_cnt == {ADDR_W{1'b1}});

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= FILL;
            wr_bank       <= 1'b0;
            wr_cnt        <= '0;
            s_ready_q     <= 1'b1;
            frame_ready_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            if (accept) wr_cnt <= wr_cnt + 1'b1;
            if (bus.s_valid && !s_ready_q) overrun_q <= 1'b1;
            unique case (state)
                FILL: begin
                    if (last) begin
                        wr_bank       <= ~wr_bank;
                        state         <= FILL_READ;
                        frame_ready_q <= 1'b1;
                    end
                end
                FILL_READ: begin
                    if (last && bus.fft_release) begin
                        wr_bank <= ~wr_bank;
                    end else if (last) begin
                        state     <= STALL;
                        s_ready_q <= 1'b0;
                    end else if (bus.fft_release) begin
                        state         <= FILL;
                        frame_ready_q <= 1'b0;
                    end
                end
                STALL: begin
                    if (bus.fft_release) begin
                        wr_bank   <= ~wr_bank;
                        state     <= FILL_READ;
                        s_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state         <= FILL;
                    s_ready_q     <= 1'b1;
                    frame_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Bank select for read data follows the bank owned in the address cycle.
    always_ff @(posedge clk) begin
        if (reset) rd_sel <= 1'b1;
        else       rd_sel <= ~wr_bank;
    end

    assign rd_addr = bus.fft_rd_bitrev
        ? ADDR_W'(bitrev(BR_MAX_W'(bus.fft_rd_addr), ADDR_W))
        : bus.fft_rd_addr;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic              own;
        logic              we;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;

        assign own   = (wr_bank == 1'(b));
        assign we    = own ? accept : bus.fft_we;
        assign waddr = own ? wr_cnt : bus.fft_wr_addr;
        assign wdata = own ? bus.s_data : bus.fft_wr_data;

        ram_bank #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_ram (
            .clk   (clk),
            .reset (reset),
            .we    (we),
            .waddr (waddr),
            .wdata (wdata),
            .raddr (rd_addr),
            .rdata (rdata[b])
        );
    end

    assign bus.s_ready     = s_ready_q;
    assign bus.frame_ready = frame_ready_q;
    assign bus.overrun     = overrun_q;
    assign bus.fft_rd_data = rd_sel ? rdata[1] : rdata[0];
endmodule

// File: tb/tb_fft_pingpong_buf.sv
// Directed bench for fft_pingpong_buf with N=8; read data is scoreboarded.
// Expected read words are queued at address time and checked a cycle later.
module tb_fft_pingpong_buf;
    localparam int DW = 32;
    localparam int AW = 3;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    bit   rd_issued;
    logic [DW-1:0] exp_q [$];

    fft_pingpong_buf_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    fft_pingpong_buf #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        logic [DW-1:0] e;
        @(posedge clk);
        #1;
        if (rd_issued) begin
            rd_issued = 1'b0;
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rd_data", bus.fft_rd_data, e);
            end
        end
    endtask

    task automatic rd(input int a, input bit br, input logic [DW-1:0] e);
        bus.fft_rd_addr   = AW'(a);
        bus.fft_rd_bitrev = br;
        exp_q.push_back(e);
        rd_issued = 1'b1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        cyc();
        bus.s_valid = 1'b0;
    endtask

    task automatic read_frame(input logic [DW-1:0] base);
        for (int i = 0; i < 8; i++) begin
            rd(i, 1'b0, base + DW'(i));
            cyc();
        end
        cyc();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rd_issued = 1'b0;
        reset = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.fft_rd_addr = '0;
        bus.fft_rd_bitrev = 1'b0;
        bus.fft_we = 1'b0;
        bus.fft_wr_addr = '0;
        bus.fft_wr_data = '0;
        bus.fft_release = 1'b0;

        cyc();
        cyc();
        chk("rst_s_ready", 32'(bus.s_ready), 32'd1);
        chk("rst_frame_ready", 32'(bus.frame_ready), 32'd0);
        chk("rst_overrun", 32'(bus.overrun), 32'd0);
        chk("rst_rd_data", bus.fft_rd_data, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            push(32'h10 + DW'(i));
            if (i == 6) chk("fr_before_last", 32'(bus.frame_ready), 32'd0);
        end
        chk("fr_after_last", 32'(bus.frame_ready), 32'd1);
        chk("s_ready_frame1", 32'(bus.s_ready), 32'd1);
        read_frame(32'h10);

        rd(1, 1'b1, 32'h14);
        cyc();
        rd(3, 1'b1, 32'h16);
        cyc();
        rd(6, 1'b1, 32'h13);
        cyc();
        cyc();

        bus.fft_we = 1'b1;
        bus.fft_wr_addr = 3'd5;
        bus.fft_wr_data = 32'hABCD;
        rd(5, 1'b0, 32'h15);
        cyc();
        bus.fft_we = 1'b0;
        rd(5, 1'b0, 32'hABCD);
        cyc();
        cyc();

        for (int i = 0; i < 8; i++) push(32'h18 + DW'(i));
        chk("stall_s_ready", 32'(bus.s_ready), 32'd0);
        chk("stall_frame_ready", 32'(bus.frame_ready), 32'd1);
        rd(0, 1'b0, 32'h10);
        cyc();
        cyc();

        push(32'hDEAD);
        chk("overrun_set", 32'(bus.overrun), 32'd1);
        cyc();
        chk("overrun_sticky", 32'(bus.overrun), 32'd1);

        bus.fft_release = 1'b1;
        cyc();
        bus.fft_release = 1'b0;
        chk("rel_s_ready", 32'(bus.s_ready), 32'd1);
        chk("rel_frame_ready", 32'(bus.frame_ready), 32'd1);
        read_frame(32'h18);

        for (int i = 0; i < 7; i++) push(32'h20 + DW'(i));
        bus.fft_release = 1'b1;
        push(32'h27);
        bus.fft_release = 1'b0;
        chk("swap_s_ready", 32'(bus.s_ready), 32'd1);
        chk("swap_frame_ready", 32'(bus.frame_ready), 32'd1);
        read_frame(32'h20);

        bus.fft_release = 1'b1;
        cyc();
        bus.fft_release = 1'b0;
        chk("to_fill_frame_ready", 32'(bus.frame_ready), 32'd0);
        chk("to_fill_s_ready", 32'(bus.s_ready), 32'd1);

        for (int i = 0; i < 4; i++) push(32'h30 + DW'(i));
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("mid_rst_frame_ready", 32'(bus.frame_ready), 32'd0);
        chk("mid_rst_s_ready", 32'(bus.s_ready), 32'd1);
        chk("mid_rst_overrun", 32'(bus.overrun), 32'd0);
        for (int i = 0; i < 8; i++) push(32'h40 + DW'(i));
        chk("fresh_frame_ready", 32'(bus.frame_ready), 32'd1);
        read_frame(32'h40);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fft_pingpong_buf.md
# fft_pingpong_buf

Parametrised two-bank sample buffer between the decimated audio sample stream and the in-place FFT core. The write side fills one bank sequentially while the FFT owns the other bank for in-place read/modify/write. Banks swap automatically when a frame completes and the FFT has released its bank. This generalises the single 512×32 RAM to arbitrary width and depth, and adds bank ownership, back-pressure, bit-reversed read addressing and overrun detection.

## Interface
- DATA_W, default 32: word width (packed re/im).
- ADDR_W, default 9: address width; frame length N = 2**ADDR_W.

- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- s_valid  in  1  sample present.
- s_data  in  DATA_W  sample word.
- s_ready  out  1  buffer accepts sample this cycle.
- frame_ready  out  1  a full bank is owned by the FFT side.
- overrun  out  1  sticky; a sample was offered while s_ready=0.
- fft_rd_addr  in  ADDR_W  FFT read address.
- fft_rd_bitrev  in  1  bit-reverse fft_rd_addr before lookup.
- fft_rd_data  out  DATA_W  registered read data.
- fft_we  in  1  FFT write strobe.
- fft_wr_addr  in  ADDR_W  FFT write address (never bit-reversed).
- fft_wr_data  in  DATA_W  FFT write data.
- fft_release  in  1  one-cycle pulse: FFT is done with its bank.

## Operation
- State: wr_bank (1 b), wr_cnt (ADDR_W b), FSM {FILL, FILL_READ, STALL}. FFT bank is always ~wr_bank.
- Reset: FSM=FILL, wr_bank=0, wr_cnt=0, overrun=0, fft_rd_data=0. Outputs after reset: s_ready=1, frame_ready=0.
- Sample accept: s_valid && s_ready. The sample is written to bank wr_bank at wr_cnt, and wr_cnt increments. The last sample is at wr_cnt==N-1, after which wr_cnt wraps to 0.
- FILL (no frame owned by FFT): s_ready=1, frame_ready=0. Last sample accepted → wr_bank toggles, enter FILL_READ. fft_release is ignored.
- FILL_READ: s_ready=1, frame_ready=1.
  - fft_release without a last sample → FILL.
  - Last sample without fft_release → STALL.
  - Last sample and fft_release in the same cycle → wr_bank toggles, stay in FILL_READ.
- STALL (fill bank full, FFT still busy): s_ready=0, frame_ready=1, wr_cnt=0. fft_release → wr_bank toggles, enter FILL_READ.
- overrun sets on s_valid && !s_ready. It clears only on reset. The rejected sample is dropped.
- The FFT port always targets bank ~wr_bank, including in FILL, where it returns stale data and writes are harmless.
- fft_we writes fft_wr_data at fft_wr_addr. Write and read to the same address in the same cycle returns the old data (read-before-write).
- Bit reverse: effective address bit i = fft_rd_addr bit ADDR_W-1-i.
- The write side and the FFT side never touch the same bank, so no arbitration is needed.

## Timing
- fft_rd_data is valid 1 cycle after fft_rd_addr is presented.
- Read bank selection uses wr_bank sampled in the address cycle. A read issued in a swap cycle returns the pre-swap bank.
- frame_ready and s_ready are combinational from FSM state (registered state, no input paths).
- s_valid → memory write: 1 cycle. The last sample makes frame_ready=1 on the next cycle.
- fft_release → frame_ready=0 (FILL_READ→FILL) or s_ready=1 (STALL→FILL_READ) on the next cycle.
- Sustained throughput is 1 sample/cycle while the FFT turns a frame around within N cycles.
- Reset mid-frame discards both banks' ownership: the partial frame is abandoned and memory contents are not cleared.

## Structure
- Package fft_buf_pkg:
  - buf_state_t enum {FILL, FILL_READ, STALL}.
  - bitrev function parametrised by width.
- Sub-module ram_bank: parametrised simple dual-port synchronous RAM with one write port and one registered read port. Instantiated twice.
- The top level muxes write enables and addresses by wr_bank and selects read data by the registered bank select.

## Test plan
Run with ADDR_W=3 (N=8), DATA_W=32.
- Reset, then stream 8 samples 0x10..0x17 → frame_ready=1 on the cycle after 0x17. Reading addr 0..7 returns 0x10..0x17 one cycle later.
- The same frame read with fft_rd_bitrev=1, addr 1 → 0x14; addr 3 → 0x16.
- Stream 16 samples without fft_release → s_ready=0 after the 16th, FSM in STALL. Pulse fft_release → s_ready=1 next cycle, and reads return the second frame (0x18..0x1F).
- In STALL, hold s_valid=1 for one cycle → overrun=1 and stays 1; that sample does not appear in the next frame.
- FILL_READ with the last sample and fft_release in the same cycle → s_ready stays 1, frame_ready stays 1, new frame readable.
- FFT writes 0xABCD to addr 5 and reads addr 5 in the same cycle → old value; read next cycle → 0xABCD. The filling bank is unaffected.
- Assert reset mid-frame (after 4 samples) → frame_ready=0, s_ready=1, overrun=0. The next 8 samples form a fresh frame starting at address 0.
